instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/vayu_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vayu_pkg.sv
// Shared fetch-stage types and defaults for the vayu core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vayu_pkg;

  localparam int              XLEN               = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int              FIFO_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One buffered fetch: instruction word plus the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between imem response and decode.
// Latency: push visible at head one cycle later; head is combinational from storage.
// Backpressure: caller must not push when full or pop when empty; clear beats push/pop.
// Ports: core_clk/rst_n (sync active-low), clear, push + push_dat, pop,
//        head_dat (oldest entry), count (0..2).
module fetch_fifo
  import vayu_pkg::*;
(
  input  logic         core_clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output fetch_entry_t head_dat,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word fetches to imem and buffers responses for decode.
// Latency: request to op_instr_valid is 2 cycles; one instruction per cycle in steady state.
// Backpressure: ip_stall holds the head; requests stop once buffered + in-flight reaches FIFO_DEPTH.
// Ports: ip_clk, ip_rst_n (sync active-low); op_imem_req/op_imem_addr out, ip_imem_rdata/
//        ip_imem_rvalid in (response exactly one cycle after request); ip_stall, ip_redirect,
//        ip_redirect_pc from downstream; op_instr/op_instr_valid/op_pc to decode.
module instr_fetch
  import vayu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic            ip_clk,
  input  logic            ip_rst_n,
  output logic            op_imem_req,
  output logic [XLEN-1:0] op_imem_addr,
  input  logic [XLEN-1:0] ip_imem_rdata,
  input  logic            ip_imem_rvalid,
  input  logic            ip_stall,
  input  logic            ip_redirect,
  input  logic [XLEN-1:0] ip_redirect_pc,
  output logic [XLEN-1:0] op_instr,
  output logic            op_instr_valid,
  output logic [XLEN-1:0] op_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            issue;

  logic            buf_vld;
  logic            drain;
  logic [1:0]      fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_in;
  logic            fifo_push;
  logic            fifo_pop;
  logic [2:0]      occupancy;

  assign buf_vld = (fifo_count != 2'd0);
  assign drain   = buf_vld && !ip_stall;

  // An entry leaving this cycle already counts as free space for a new request.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, drain};

  // Redirect outranks push and pop: the buffer is cleared instead.
  assign fifo_pop  = drain && !ip_redirect;
  // Only a response we actually asked for (and did not squash) is buffered.
  assign fifo_push = ip_imem_rvalid && inflight_q && !ip_redirect;
  assign fifo_in   = '{instr: ip_imem_rdata, pc: inflight_pc_q};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     issue   = (occupancy < 3'(FIFO_DEPTH));
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (ip_redirect) begin
      state_d = FLUSH;
      issue   = 1'b0;
    end
    if (!ip_rst_n) begin
      issue = 1'b0;
    end
  end

  always_ff @(posedge ip_clk) begin
    if (!ip_rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      // issue is forced low on redirect, so this also squashes nothing new.
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
      end
      if (ip_redirect) begin
        fetch_pc_q <= ip_redirect_pc & ~32'h0000_0003;
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;  // natural 32-bit wrap
      end
    end
  end

  fetch_fifo u_fetch_fifo (
    .core_clk (ip_clk),
    .rst_n    (ip_rst_n),
    .clear    (ip_redirect),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );

  assign op_imem_req    = issue;
  assign op_imem_addr   = fetch_pc_q;
  assign op_instr_valid = ip_rst_n && buf_vld;
  // Zero when nothing is presented so reset shows clean outputs.
  assign op_instr       = op_instr_valid ? fifo_head.instr : '0;
  assign op_pc          = op_instr_valid ? fifo_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: imem responder, negedge scoreboard, scenario tasks.
// Latency: n/a.
// Backpressure: stall and redirect driven per scenario.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hC0DE_5A5A;

  logic        ip_clk = 1'b0;
  logic        ip_rst_n = 1'b0;
  logic        op_imem_req;
  logic [31:0] op_imem_addr;
  logic [31:0] ip_imem_rdata = 32'h0;
  logic        ip_imem_rvalid = 1'b0;
  logic        ip_stall = 1'b0;
  logic        ip_redirect = 1'b0;
  logic [31:0] ip_redirect_pc = 32'h0;
  logic [31:0] op_instr;
  logic        op_instr_valid;
  logic [31:0] op_pc;

  int n_pass = 0;
  int n_total = 0;

  logic        mem_req_q = 1'b0;
  logic [31:0] mem_addr_q = 32'h0;
  logic        inject = 1'b0;
  logic        legit_q = 1'b0;
  logic [31:0] legit_addr = 32'h0;
  logic [63:0] sb_q [$];
  logic [63:0] sb_exp;

  instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .ip_clk         (ip_clk),
    .ip_rst_n       (ip_rst_n),
    .op_imem_req    (op_imem_req),
    .op_imem_addr   (op_imem_addr),
    .ip_imem_rdata  (ip_imem_rdata),
    .ip_imem_rvalid (ip_imem_rvalid),
    .ip_stall       (ip_stall),
    .ip_redirect    (ip_redirect),
    .ip_redirect_pc (ip_redirect_pc),
    .op_instr       (op_instr),
    .op_instr_valid (op_instr_valid),
    .op_pc          (op_pc)
  );

  always #5 ip_clk = ~ip_clk;

  // Instruction memory: answers exactly one cycle after a request; inject forces a stray strobe.
  always @(posedge ip_clk) begin
    #2;
    ip_imem_rvalid = mem_req_q | inject;
    ip_imem_rdata  = mem_req_q ? (mem_addr_q ^ MAGIC) : 32'hBAD0_0BAD;
  end

  // Scoreboard: expected entries queued when a genuine response is driven, compared on pop.
  always @(negedge ip_clk) begin
    if (!ip_rst_n) begin
      sb_q.delete();
      legit_q = 1'b0;
    end else if (ip_redirect) begin
      n_total++;
      if (op_imem_req !== 1'b0) $display("FAIL sb_redirect_req: got %b want 0", op_imem_req);
      else n_pass++;
      sb_q.delete();
      legit_q = 1'b0;
    end else begin
      n_total++;
      if (op_instr_valid !== (sb_q.size() != 0))
        $display("FAIL sb_valid: got %b want %b (pc %h)", op_instr_valid, sb_q.size() != 0, op_pc);
      else n_pass++;
      if (op_instr_valid === 1'b1 && sb_q.size() != 0) begin
        sb_exp = sb_q[0];
        n_total++;
        if ({op_instr, op_pc} !== sb_exp)
          $display("FAIL sb_data: got %h/%h want %h/%h", op_instr, op_pc, sb_exp[63:32], sb_exp[31:0]);
        else n_pass++;
        if (!ip_stall) void'(sb_q.pop_front());
      end
      if (ip_imem_rvalid && legit_q) sb_q.push_back({legit_addr ^ MAGIC, legit_addr});
      legit_q    = op_imem_req;
      legit_addr = op_imem_addr;
    end
    mem_req_q  = op_imem_req;
    mem_addr_q = op_imem_addr;
  end

  task automatic next_cycle();
    @(posedge ip_clk);
    #1;
  endtask

  task automatic test_reset();
    ip_rst_n = 1'b0;
    repeat (2) next_cycle();
    #2;
    n_total++; if (op_imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", op_imem_req); else n_pass++;
    n_total++; if (op_instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", op_instr_valid); else n_pass++;
    n_total++; if (op_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", op_instr); else n_pass++;
    n_total++; if (op_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", op_pc); else n_pass++;
    n_total++; if (op_imem_addr !== RESET_PC) $display("FAIL rst_addr: got %h want %h", op_imem_addr, RESET_PC); else n_pass++;
  endtask

  task automatic test_boot();
    next_cycle();
    ip_rst_n = 1'b1;
    inject   = 1'b1;  // stray response right after release must be ignored
    #2;
    n_total++; if (op_imem_req !== 1'b0) $display("FAIL boot_req: got %b want 0", op_imem_req); else n_pass++;
    next_cycle();
    inject = 1'b0;
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== 32'h0) $display("FAIL boot_req0: got %b/%h want 1/0", op_imem_req, op_imem_addr); else n_pass++;
    n_total++; if (op_instr_valid !== 1'b0) $display("FAIL boot_stray: got %b want 0", op_instr_valid); else n_pass++;
    next_cycle();
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== 32'h4) $display("FAIL boot_req4: got %b/%h want 1/4", op_imem_req, op_imem_addr); else n_pass++;
    n_total++; if (op_instr_valid !== 1'b0) $display("FAIL boot_early: got %b want 0", op_instr_valid); else n_pass++;
    next_cycle();
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== 32'h8) $display("FAIL boot_req8: got %b/%h want 1/8", op_imem_req, op_imem_addr); else n_pass++;
    n_total++; if (op_instr_valid !== 1'b1 || op_pc !== 32'h0) $display("FAIL boot_first: got %b/%h want 1/0", op_instr_valid, op_pc); else n_pass++;
  endtask

  task automatic test_stall();
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle();
      #2;
      if (op_instr_valid === 1'b1 && op_pc === 32'h8) found = 1;
    end
    n_total++; if (!found) $display("FAIL stall_find: got no head at 8 want head 8"); else n_pass++;
    ip_stall = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) begin
        next_cycle();
        #2;
      end
      n_total++; if (op_imem_req !== 1'b0) $display("FAIL stall_req c%0d: got %b want 0", c, op_imem_req); else n_pass++;
      n_total++; if (op_instr_valid !== 1'b1 || op_pc !== 32'h8 || op_instr !== (32'h8 ^ MAGIC))
        $display("FAIL stall_hold c%0d: got %b/%h/%h want 1/8/%h", c, op_instr_valid, op_pc, op_instr, 32'h8 ^ MAGIC);
      else n_pass++;
    end
    next_cycle();
    ip_stall = 1'b0;
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== 32'h10) $display("FAIL stall_resume: got %b/%h want 1/10", op_imem_req, op_imem_addr); else n_pass++;
    n_total++; if (op_pc !== 32'h8) $display("FAIL stall_order0: got %h want 8", op_pc); else n_pass++;
    next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1 || op_pc !== 32'hC) $display("FAIL stall_order1: got %b/%h want 1/c", op_instr_valid, op_pc); else n_pass++;
    next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1 || op_pc !== 32'h10) $display("FAIL stall_order2: got %b/%h want 1/10", op_instr_valid, op_pc); else n_pass++;
  endtask

  task automatic test_redirect();
    next_cycle();
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'h0000_0102;
    #2;
    n_total++; if (op_imem_req !== 1'b0) $display("FAIL redir_req: got %b want 0", op_imem_req); else n_pass++;
    next_cycle();
    ip_redirect = 1'b0;
    #2;
    n_total++; if (op_instr_valid !== 1'b0) $display("FAIL redir_empty: got %b want 0", op_instr_valid); else n_pass++;
    n_total++; if (op_imem_req !== 1'b0) $display("FAIL redir_flush_req: got %b want 0", op_imem_req); else n_pass++;
    next_cycle();
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== 32'h100) $display("FAIL redir_addr: got %b/%h want 1/100", op_imem_req, op_imem_addr); else n_pass++;
    next_cycle();
    next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1 || op_pc !== 32'h100) $display("FAIL redir_first: got %b/%h want 1/100", op_instr_valid, op_pc); else n_pass++;
  endtask

  task automatic test_redirect_in_flush();
    next_cycle();
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'h200;
    next_cycle();
    ip_redirect_pc = 32'h300;
    #2;
    n_total++; if (op_imem_req !== 1'b0 || op_instr_valid !== 1'b0) $display("FAIL reflush_quiet: got %b/%b want 0/0", op_imem_req, op_instr_valid); else n_pass++;
    next_cycle();
    ip_redirect = 1'b0;
    #2;
    n_total++; if (op_imem_req !== 1'b0) $display("FAIL reflush_req: got %b want 0", op_imem_req); else n_pass++;
    next_cycle();
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== 32'h300) $display("FAIL reflush_addr: got %b/%h want 1/300", op_imem_req, op_imem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr;
    next_cycle();
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    ip_redirect = 1'b0;
    exp_addr = 32'hFFFF_FFF8;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #2;
      n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== exp_addr) $display("FAIL wrap_addr c%0d: got %b/%h want 1/%h", c, op_imem_req, op_imem_addr, exp_addr); else n_pass++;
      exp_addr = exp_addr + 32'd4;
    end
    next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1 || op_pc !== 32'h0) $display("FAIL wrap_pc: got %b/%h want 1/0", op_instr_valid, op_pc); else n_pass++;
  endtask

  task automatic test_redirect_push_pop();
    bit found = 0;
    next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1) $display("FAIL rpp_pre: got %b want 1", op_instr_valid); else n_pass++;
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'h400;
    next_cycle();
    ip_redirect = 1'b0;
    #2;
    n_total++; if (op_instr_valid !== 1'b0) $display("FAIL rpp_stale: got %b want 0", op_instr_valid); else n_pass++;
    for (int i = 0; i < 8 && !found; i++) begin
      next_cycle();
      #2;
      if (op_instr_valid === 1'b1) found = 1;
    end
    n_total++; if (!found || op_pc !== 32'h400) $display("FAIL rpp_first: got %b/%h want 1/400", found, op_pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    ip_stall = 1'b1;
    repeat (2) next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1 || op_imem_req !== 1'b0) $display("FAIL rmid_full: got %b/%b want 1/0", op_instr_valid, op_imem_req); else n_pass++;
    next_cycle();
    ip_rst_n = 1'b0;
    #2;
    n_total++; if (op_imem_req !== 1'b0 || op_instr_valid !== 1'b0) $display("FAIL rmid_during: got %b/%b want 0/0", op_imem_req, op_instr_valid); else n_pass++;
    next_cycle();
    ip_rst_n = 1'b1;
    inject   = 1'b1;
    #2;
    n_total++; if (op_imem_req !== 1'b0 || op_instr_valid !== 1'b0) $display("FAIL rmid_after: got %b/%b want 0/0", op_imem_req, op_instr_valid); else n_pass++;
    n_total++; if (op_instr !== 32'h0 || op_pc !== 32'h0) $display("FAIL rmid_data: got %h/%h want 0/0", op_instr, op_pc); else n_pass++;
    n_total++; if (op_imem_addr !== RESET_PC) $display("FAIL rmid_addr: got %h want %h", op_imem_addr, RESET_PC); else n_pass++;
    next_cycle();
    inject   = 1'b0;
    ip_stall = 1'b0;
    #2;
    n_total++; if (op_imem_req !== 1'b1 || op_imem_addr !== RESET_PC) $display("FAIL rmid_req: got %b/%h want 1/%h", op_imem_req, op_imem_addr, RESET_PC); else n_pass++;
    n_total++; if (op_instr_valid !== 1'b0) $display("FAIL rmid_stray: got %b want 0", op_instr_valid); else n_pass++;
    next_cycle();
    next_cycle();
    #2;
    n_total++; if (op_instr_valid !== 1'b1 || op_pc !== RESET_PC) $display("FAIL rmid_first: got %b/%h want 1/%h", op_instr_valid, op_pc, RESET_PC); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_redirect_in_flush();
    test_wrap();
    test_redirect_push_pop();
    test_reset_mid();
    repeat (3) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
